// File: rtl/hazard_flush_ctrl_if.sv
// Hazard/flush control bundle between the pipeline datapath and hazard_flush_ctrl.
// master = pipeline side (drives stage status), slave = controller (drives stage controls).
interface hazard_flush_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  mem_busy;
    logic                  wb_redirect;
    logic [ADDR_W-1:0]     wb_target;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_write;
    logic                  exmem_write;
    logic                  idex_bubble;
    logic                  memwb_bubble;
    logic                  flush_ifid;
    logic                  flush_idex;
    logic                  flush_exmem;
    logic                  mem_abort;
    logic                  pc_redirect;
    logic [ADDR_W-1:0]     pc_target;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, mem_busy, wb_redirect, wb_target,
        input  pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble,
               flush_ifid, flush_idex, flush_exmem, mem_abort, pc_redirect, pc_target
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, mem_busy, wb_redirect, wb_target,
        output pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble,
               flush_ifid, flush_idex, flush_exmem, mem_abort, pc_redirect, pc_target
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: WB redirects, data-memory waits, load-use stalls (HAZARD_PERF_EN adds counters).
// Latency: controls are Mealy (same cycle); pc_target registered; redirect costs 2 cycles, load-use 1 cycle.
// Backpressure: mem_busy freezes all stage enables and bubbles MEM/WB until it drops; a redirect overrides it.
module hazard_flush_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_flush_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        wait_cnt,
    output logic [15:0]        redirect_cnt
`endif
);

    typedef enum logic [1:0] {RUN, MEMWAIT, REDIRECT} stateT;

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] tgtQ;
    logic              loadTgt;
    logic              loadUse;

    assign loadUse = bus.ex_mem_read
                  && (bus.ex_rt != {REG_ADDR_W{1'b0}})
                  && ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // Falling edge, shared with the pipeline registers this block steers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            tgtQ  <= '0;
        end else begin
            state <= nextState;
            if (loadTgt) tgtQ <= bus.wb_target;
        end
    end

    always_comb begin
        nextState        = state;
        loadTgt          = 1'b0;
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.idex_write   = 1'b0;
        bus.exmem_write  = 1'b0;
        bus.idex_bubble  = 1'b0;
        bus.memwb_bubble = 1'b0;
        bus.flush_ifid   = 1'b0;
        bus.flush_idex   = 1'b0;
        bus.flush_exmem  = 1'b0;
        bus.mem_abort    = 1'b0;
        bus.pc_redirect  = 1'b0;
        if (reset) begin
            case (state)
                REDIRECT: begin
                    // WB holds a flushed bubble here, so its redirect flag is stale.
                    bus.pc_write    = 1'b1;
                    bus.ifid_write  = 1'b1;
                    bus.idex_write  = 1'b1;
                    bus.exmem_write = 1'b1;
                    bus.pc_redirect = 1'b1;
                    bus.flush_ifid  = 1'b1;
                    nextState       = RUN;
                end
                default: begin
                    if (bus.wb_redirect) begin
                        bus.ifid_write  = 1'b1;
                        bus.idex_write  = 1'b1;
                        bus.exmem_write = 1'b1;
                        bus.flush_ifid  = 1'b1;
                        bus.flush_idex  = 1'b1;
                        bus.flush_exmem = 1'b1;
                        bus.mem_abort   = bus.mem_busy;
                        loadTgt         = 1'b1;
                        nextState       = REDIRECT;
                    end else if (bus.mem_busy) begin
                        bus.memwb_bubble = 1'b1;
                        nextState        = MEMWAIT;
                    end else begin
                        // Also the release cycle of a wait, so the hazard is re-checked here.
                        bus.pc_write    = !loadUse;
                        bus.ifid_write  = !loadUse;
                        bus.idex_write  = 1'b1;
                        bus.exmem_write = 1'b1;
                        bus.idex_bubble = loadUse;
                        nextState       = RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_target = tgtQ;

`ifdef HAZARD_PERF_EN
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            wait_cnt     <= '0;
            redirect_cnt <= '0;
        end else begin
            if (bus.idex_bubble && (stall_cnt != 16'hFFFF))     stall_cnt    <= stall_cnt + 16'd1;
            if (bus.memwb_bubble && (wait_cnt != 16'hFFFF))     wait_cnt     <= wait_cnt + 16'd1;
            if (loadTgt && (redirect_cnt != 16'hFFFF))          redirect_cnt <= redirect_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: inputs change just after the falling (active) edge, outputs sampled on the rising edge.
module tb_hazard_flush_ctrl;

    logic clk;
    logic reset;
    int   passCnt;
    int   checkCnt;

    hazard_flush_ctrl_if #(.REG_ADDR_W(5), .ADDR_W(32)) bus ();

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] wait_cnt;
    logic [15:0] redirect_cnt;
`endif

    hazard_flush_ctrl #(.REG_ADDR_W(5), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .wait_cnt     (wait_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble,
    //  flush_ifid, flush_idex, flush_exmem, mem_abort, pc_redirect}
    logic [10:0] ctl;
    assign ctl = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                  bus.idex_bubble, bus.memwb_bubble, bus.flush_ifid, bus.flush_idex,
                  bus.flush_exmem, bus.mem_abort, bus.pc_redirect};

    localparam logic [10:0] OFF   = 11'h000;
    localparam logic [10:0] RUNV  = 11'h780;
    localparam logic [10:0] STALL = 11'h1C0;
    localparam logic [10:0] WAITV = 11'h020;
    localparam logic [10:0] DET   = 11'h39C;
    localparam logic [10:0] DETAB = 11'h39E;
    localparam logic [10:0] REDIR = 11'h791;

    task automatic idle();
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.id_uses_rt  = 1'b0;
        bus.ex_rt       = 5'd0;
        bus.ex_mem_read = 1'b0;
        bus.mem_busy    = 1'b0;
        bus.wb_redirect = 1'b0;
        bus.wb_target   = 32'h0;
    endtask

    task automatic nextCyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== OFF) $display("FAIL reset_ctl: got %h expected %h", ctl, OFF); else passCnt++;
        checkCnt++;
        if (bus.pc_target !== 32'h0) $display("FAIL reset_target: got %h expected 0", bus.pc_target); else passCnt++;
        nextCyc();
        reset = 1'b1;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL reset_release_run: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
    endtask

    task automatic test_load_use();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        @(posedge clk);
        checkCnt++;
        if (ctl !== STALL) $display("FAIL load_use_rs: got %h expected %h", ctl, STALL); else passCnt++;
        nextCyc();
        idle();
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL load_use_cleared: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL load_use_r0: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        idle();
    endtask

    task automatic test_rt_select();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3; bus.id_uses_rt = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL rt_unused: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        bus.id_uses_rt = 1'b1;
        @(posedge clk);
        checkCnt++;
        if (ctl !== STALL) $display("FAIL rt_used: got %h expected %h", ctl, STALL); else passCnt++;
        nextCyc();
        bus.ex_mem_read = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL rt_not_load: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        idle();
    endtask

    task automatic test_mem_wait();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            checkCnt++;
            if (ctl !== WAITV) $display("FAIL mem_wait_%0d: got %h expected %h", i, ctl, WAITV); else passCnt++;
            nextCyc();
        end
        bus.mem_busy = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL mem_wait_release: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        // a pending load-use hazard loses to the wait, then stalls once it ends
        bus.mem_busy = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
        @(posedge clk);
        checkCnt++;
        if (ctl !== WAITV) $display("FAIL wait_over_hazard: got %h expected %h", ctl, WAITV); else passCnt++;
        nextCyc();
        bus.mem_busy = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== STALL) $display("FAIL hazard_after_wait: got %h expected %h", ctl, STALL); else passCnt++;
        nextCyc();
        idle();
    endtask

    task automatic test_redirect();
        bus.wb_redirect = 1'b1; bus.wb_target = 32'h0040_0100;
        @(posedge clk);
        checkCnt++;
        if (ctl !== DET) $display("FAIL redirect_detect: got %h expected %h", ctl, DET); else passCnt++;
        nextCyc();
        // left high: the flushed WB slot must not re-trigger
        bus.wb_target = 32'h1111_2222;
        @(posedge clk);
        checkCnt++;
        if (ctl !== REDIR) $display("FAIL redirect_cycle: got %h expected %h", ctl, REDIR); else passCnt++;
        checkCnt++;
        if (bus.pc_target !== 32'h0040_0100) $display("FAIL redirect_target: got %h expected 00400100", bus.pc_target); else passCnt++;
        nextCyc();
        bus.wb_redirect = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL redirect_back_run: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
        idle();
    endtask

    task automatic test_reset_mid_redirect();
        bus.wb_redirect = 1'b1; bus.wb_target = 32'hDEAD_BEE0;
        @(posedge clk);
        nextCyc();
        bus.wb_redirect = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (bus.pc_target !== 32'hDEAD_BEE0) $display("FAIL pre_reset_target: got %h expected deadbee0", bus.pc_target); else passCnt++;
        #1 reset = 1'b0;
        #1;
        checkCnt++;
        if (ctl !== OFF) $display("FAIL async_reset_ctl: got %h expected %h", ctl, OFF); else passCnt++;
        checkCnt++;
        if (bus.pc_target !== 32'h0) $display("FAIL async_reset_target: got %h expected 0", bus.pc_target); else passCnt++;
        nextCyc();
        reset = 1'b1;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL redirect_discarded: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
    endtask

    task automatic test_reset_mid_wait();
        bus.mem_busy = 1'b1;
        @(posedge clk);
        nextCyc();
        @(posedge clk);
        checkCnt++;
        if (ctl !== WAITV) $display("FAIL wait_before_reset: got %h expected %h", ctl, WAITV); else passCnt++;
        nextCyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            checkCnt++;
            if (ctl !== OFF) $display("FAIL reset_in_wait_%0d: got %h expected %h", i, ctl, OFF); else passCnt++;
            nextCyc();
        end
        reset = 1'b1;
        bus.mem_busy = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL wait_discarded: got %h expected %h", ctl, RUNV); else passCnt++;
        checkCnt++;
        if (bus.pc_target !== 32'h0) $display("FAIL target_after_reset: got %h expected 0", bus.pc_target); else passCnt++;
        nextCyc();
        idle();
    endtask

    task automatic test_redirect_priority();
`ifdef HAZARD_PERF_EN
        logic [15:0] s0, w0, r0;
        s0 = stall_cnt; w0 = wait_cnt; r0 = redirect_cnt;
`endif
        bus.wb_redirect = 1'b1; bus.wb_target = 32'h0000_ABC0; bus.mem_busy = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4;
        @(posedge clk);
        checkCnt++;
        if (ctl !== DETAB) $display("FAIL redirect_over_all: got %h expected %h", ctl, DETAB); else passCnt++;
        nextCyc();
        idle();
        @(posedge clk);
        checkCnt++;
        if (ctl !== REDIR) $display("FAIL priority_redirect_cycle: got %h expected %h", ctl, REDIR); else passCnt++;
        checkCnt++;
        if (bus.pc_target !== 32'h0000_ABC0) $display("FAIL priority_target: got %h expected 0000abc0", bus.pc_target); else passCnt++;
        nextCyc();
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL no_memwait_after: got %h expected %h", ctl, RUNV); else passCnt++;
`ifdef HAZARD_PERF_EN
        checkCnt++;
        if (redirect_cnt !== r0 + 16'd1) $display("FAIL perf_redirect: got %0d expected %0d", redirect_cnt, r0 + 16'd1); else passCnt++;
        checkCnt++;
        if (stall_cnt !== s0) $display("FAIL perf_stall: got %0d expected %0d", stall_cnt, s0); else passCnt++;
        checkCnt++;
        if (wait_cnt !== w0) $display("FAIL perf_wait: got %0d expected %0d", wait_cnt, w0); else passCnt++;
`endif
        nextCyc();
        // redirect arriving while already in MEMWAIT
        bus.mem_busy = 1'b1;
        @(posedge clk);
        nextCyc();
        bus.wb_redirect = 1'b1; bus.wb_target = 32'h0000_5550;
        @(posedge clk);
        checkCnt++;
        if (ctl !== DETAB) $display("FAIL redirect_in_memwait: got %h expected %h", ctl, DETAB); else passCnt++;
        nextCyc();
        idle();
        @(posedge clk);
        checkCnt++;
        if (ctl !== REDIR) $display("FAIL memwait_redirect_cycle: got %h expected %h", ctl, REDIR); else passCnt++;
        nextCyc();
    endtask

    task automatic test_back_to_back();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2; bus.id_rs = 5'd2;
        @(posedge clk);
        checkCnt++;
        if (ctl !== STALL) $display("FAIL b2b_stall_a: got %h expected %h", ctl, STALL); else passCnt++;
        nextCyc();
        bus.ex_rt = 5'd6; bus.id_rs = 5'd1; bus.id_rt = 5'd6; bus.id_uses_rt = 1'b1;
        @(posedge clk);
        checkCnt++;
        if (ctl !== STALL) $display("FAIL b2b_stall_b: got %h expected %h", ctl, STALL); else passCnt++;
        nextCyc();
        idle();
        bus.wb_redirect = 1'b1; bus.wb_target = 32'h0000_1000;
        @(posedge clk);
        checkCnt++;
        if (ctl !== DET) $display("FAIL b2b_detect_a: got %h expected %h", ctl, DET); else passCnt++;
        nextCyc();
        bus.wb_target = 32'h0000_2000;
        @(posedge clk);
        checkCnt++;
        if (ctl !== REDIR) $display("FAIL b2b_redirect_a: got %h expected %h", ctl, REDIR); else passCnt++;
        nextCyc();
        @(posedge clk);
        checkCnt++;
        if (ctl !== DET) $display("FAIL b2b_detect_b: got %h expected %h", ctl, DET); else passCnt++;
        nextCyc();
        bus.wb_redirect = 1'b0;
        @(posedge clk);
        checkCnt++;
        if (bus.pc_target !== 32'h0000_2000) $display("FAIL b2b_target_b: got %h expected 00002000", bus.pc_target); else passCnt++;
        nextCyc();
        @(posedge clk);
        checkCnt++;
        if (ctl !== RUNV) $display("FAIL b2b_end_run: got %h expected %h", ctl, RUNV); else passCnt++;
        nextCyc();
    endtask

    initial begin
        passCnt  = 0;
        checkCnt = 0;
        reset    = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_rt_select();
        test_mem_wait();
        test_redirect();
        test_reset_mid_redirect();
        test_reset_mid_wait();
        test_redirect_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Pipeline control block that drives the write enables, bubbles and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and redirects the PC. It consumes the control state held in the MEM/WB and ID/EX registers, in the reverse direction of the forward data path. It resolves three events: redirects (jump or taken branch) retired at writeback, multi-cycle data-memory waits, and load-use hazards. It sits beside the pipeline registers and feeds the PC register and all four stage registers.

## Interface
Parameters:
- REG_ADDR_W, 5: register-file address width.
- ADDR_W, 32: PC / target width.

Ports:
- clk  in  1  clock; state updates on the falling edge, the same edge as the pipeline registers.
- reset  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rt  in  REG_ADDR_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- mem_busy  in  1  data memory is not finishing this cycle.
- wb_redirect  in  1  WB instruction is a jump or a taken branch (CtrlJump or PCOrBranch from MEM/WB).
- wb_target  in  ADDR_W  redirect address from MEM/WB JumpAddress.
- pc_write, ifid_write, idex_write, exmem_write  out  1  stage write enables.
- idex_bubble, memwb_bubble  out  1  load zeroed control into ID/EX or MEM/WB.
- flush_ifid, flush_idex, flush_exmem  out  1  zero the stage register on the next edge.
- mem_abort  out  1  cancel the pending data-memory access.
- pc_redirect  out  1  PC loads pc_target.
- pc_target  out  ADDR_W  registered redirect address.

## Operation
- States: RUN, MEMWAIT, REDIRECT. Internal registers: state and tgt_q.
- Priority in every state: redirect > memory wait > load-use.
- Redirect detect (wb_redirect=1 in RUN or MEMWAIT):
  - flush_ifid, flush_idex and flush_exmem are 1; pc_write is 0.
  - mem_abort is 1 if mem_busy is 1.
  - tgt_q is loaded with wb_target; next state is REDIRECT.
- REDIRECT (exactly one cycle):
  - pc_redirect is 1 and pc_target is tgt_q.
  - flush_ifid is 1, to kill the one wrong-path fetch.
  - wb_redirect is ignored, because the WB slot is a flushed bubble.
  - Next state is RUN.
- Memory wait (mem_busy=1, no redirect):
  - pc_write, ifid_write, idex_write and exmem_write are 0; memwb_bubble is 1.
  - State is MEMWAIT while mem_busy=1, then RUN in the first cycle mem_busy=0. That cycle runs as a normal RUN cycle.
- Load-use (RUN, no redirect, mem_busy=0):
  - Hazard condition: ex_mem_read=1, ex_rt≠0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
  - On a hazard: pc_write=0, ifid_write=0, idex_bubble=1; the other enables stay 1.
  - Single cycle and no state change; the hazard clears once the load moves to MEM.
- Default RUN outputs: all write enables 1; all bubbles, flushes, mem_abort and pc_redirect 0.
- Register 0 never triggers a load-use stall.

## Timing
- Outputs are Mealy: combinational from state and inputs, except pc_target = tgt_q.
- While reset=0 (and during reset), all outputs are 0, state is RUN, and tgt_q is 0.
- Asserting reset mid-REDIRECT or mid-MEMWAIT discards the pending redirect or wait.
- Redirect penalty is 2 cycles: the detect cycle plus the REDIRECT cycle. The first correct-path fetch occurs on the edge that ends REDIRECT.
- A load-use stall costs exactly 1 cycle.
- mem_busy and a hazard together: MEMWAIT wins. The hazard is re-evaluated after the wait.
- wb_redirect with mem_busy=1: the redirect wins, mem_abort=1, and MEMWAIT is never entered.

## Configuration
- HAZARD_PERF_EN defined: adds three 16-bit saturating counters (stall_cnt, wait_cnt, redirect_cnt) as outputs, all reset to 0.
  - stall_cnt increments per load-use stall cycle.
  - wait_cnt increments per MEMWAIT cycle.
  - redirect_cnt increments per REDIRECT entry.
  - Each counter holds at 0xFFFF.
- HAZARD_PERF_EN not defined: the counters and their ports are absent, and the rest of the behaviour is identical.

## Test plan
- Reset low for 3 cycles mid-MEMWAIT -> all outputs 0; after release, state is RUN, enables are 1, and pc_target is 0.
- ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Same with ex_rt=0 -> no stall.
- id_rt=7, ex_rt=7, id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- mem_busy=1 for 4 cycles -> 4 cycles with all enables 0 and memwb_bubble=1, then normal RUN.
- wb_redirect=1, wb_target=0x0040_0100 -> flushes and pc_write=0; next cycle pc_redirect=1, pc_target=0x0040_0100, flush_ifid=1; then RUN.
- wb_redirect=1 with mem_busy=1 and a load-use hazard present -> redirect path taken with mem_abort=1, no stall; with HAZARD_PERF_EN defined, redirect_cnt=1 and stall_cnt=0.
